// File: rtl/mem_access_unit.sv
// MEM stage: issues loads/stores to a ready/ack memory port and produces
// the MEM/WB bundle, with misalignment and ack-timeout exceptions.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_misalign,
    output logic        exc_timeout
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic        is_mem;
    logic        accept;
    logic        misalign;
    logic        timeout_hit;
    logic        lat_read;
    logic        lat_reg_write;
    logic [4:0]  lat_rd;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, op classification and the combinational stall.
    always_comb begin
        is_mem      = ex_mem_read | ex_mem_write;
        accept      = 1'b0;
        misalign    = 1'b0;
        timeout_hit = 1'b0;
        stall       = 1'b0;
        state_next  = state;
        unique case (state)
            IDLE: begin
                accept   = ex_valid && is_mem && (ex_alu_out[1:0] == 2'b00);
                misalign = ex_valid && is_mem && (ex_alu_out[1:0] != 2'b00);
                stall    = accept;
                if (accept) state_next = ACCESS;
            end
            ACCESS: begin
                stall       = 1'b1;
                // A same-cycle ack takes priority over the timeout.
                timeout_hit = !mem_ack && (count == LAST);
                if (mem_ack || timeout_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) stall = 1'b0;
    end

    // Memory port, latched op, cycle counter and MEM/WB bundle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            count         <= '0;
            lat_read      <= 1'b0;
            lat_reg_write <= 1'b0;
            lat_rd        <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            exc_misalign  <= 1'b0;
            exc_timeout   <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            exc_misalign <= 1'b0;
            exc_timeout  <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    mem_req       <= 1'b1;
                    mem_we        <= ex_mem_write;
                    mem_addr      <= ex_alu_out;
                    mem_wdata     <= ex_wdata;
                    count         <= '0;
                    lat_read      <= ex_mem_read && !ex_mem_write;
                    lat_reg_write <= ex_reg_write;
                    lat_rd        <= ex_rd;
                end else if (ex_valid) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= ex_rd;
                    wb_data      <= ex_alu_out;
                    wb_reg_write <= ex_reg_write && !misalign;
                    exc_misalign <= misalign;
                end
            end else begin
                if (mem_ack) begin
                    mem_req      <= 1'b0;
                    mem_we       <= 1'b0;
                    wb_valid     <= 1'b1;
                    wb_rd        <= lat_rd;
                    wb_data      <= lat_read ? mem_rdata : mem_addr;
                    wb_reg_write <= lat_read && lat_reg_write;
                end else if (timeout_hit) begin
                    mem_req      <= 1'b0;
                    mem_we       <= 1'b0;
                    wb_valid     <= 1'b1;
                    wb_rd        <= lat_rd;
                    wb_data      <= '0;
                    wb_reg_write <= 1'b0;
                    exc_timeout  <= 1'b1;
                end else begin
                    count <= count + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized ops checked against a per-op cycle-count reference model.
module tb_mem_access_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misalign;
    logic        exc_timeout;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .ex_alu_out(ex_alu_out), .ex_wdata(ex_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_misalign(exc_misalign), .exc_timeout(exc_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        ex_mem_read = 1'b0;
        ex_mem_write = 1'b0;
        ex_reg_write = 1'b0;
        ex_rd = '0;
        ex_alu_out = '0;
        ex_wdata = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
    endtask

    // ALU op: result appears one edge later, never stalls.
    task automatic run_alu(input logic [4:0] rd, input logic [31:0] val,
                           input logic rw);
        @(negedge clk);
        ex_valid = 1'b1;
        ex_mem_read = 1'b0;
        ex_mem_write = 1'b0;
        ex_reg_write = rw;
        ex_rd = rd;
        ex_alu_out = val;
        #1;
        chk("alu_stall_pre", stall, 0);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_rd", wb_rd, rd);
        chk("alu_wb_data", wb_data, val);
        chk("alu_wb_rw", wb_reg_write, rw);
        chk("alu_stall_post", stall, 0);
        chk("alu_mem_req", mem_req, 0);
    endtask

    // Memory op. ack_at = ACCESS cycle (1-based) carrying mem_ack, 0 = never.
    task automatic run_mem(input logic rd_op, input logic wr_op,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd, input logic rw,
                           input int ack_at, input logic [31:0] rdata);
        bit aligned;
        bit acked;
        bit is_load;
        int n;
        aligned = (addr % 4) == 0;
        acked = (ack_at >= 1) && (ack_at <= TO);
        n = acked ? ack_at : TO;
        is_load = rd_op && !wr_op;
        @(negedge clk);
        ex_valid = 1'b1;
        ex_mem_read = rd_op;
        ex_mem_write = wr_op;
        ex_reg_write = rw;
        ex_rd = rd;
        ex_alu_out = addr;
        ex_wdata = wd;
        #1;
        chk("mem_stall_present", stall, aligned);
        chk("mem_req_present", mem_req, 0);
        if (!aligned) begin
            @(negedge clk);
            ex_valid = 1'b0;
            #1;
            chk("mis_req", mem_req, 0);
            chk("mis_exc", exc_misalign, 1);
            chk("mis_wb_valid", wb_valid, 1);
            chk("mis_wb_rw", wb_reg_write, 0);
            chk("mis_stall", stall, 0);
            @(negedge clk);
            #1;
            chk("mis_exc_pulse", exc_misalign, 0);
            chk("mis_wb_pulse", wb_valid, 0);
            chk("mis_req_after", mem_req, 0);
            return;
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            ex_valid = 1'($urandom);
            ex_mem_read = 1'($urandom);
            ex_mem_write = 1'($urandom);
            ex_reg_write = 1'($urandom);
            ex_rd = 5'($urandom);
            ex_alu_out = $urandom;
            ex_wdata = $urandom;
            mem_ack = acked && (k == ack_at);
            mem_rdata = (acked && (k == ack_at)) ? rdata : $urandom;
            #1;
            chk("acc_req", mem_req, 1);
            chk("acc_we", mem_we, wr_op);
            chk("acc_addr", mem_addr, addr);
            chk("acc_wdata", mem_wdata, wd);
            chk("acc_stall", stall, 1);
            chk("acc_wb_valid", wb_valid, 0);
            chk("acc_exc_to", exc_timeout, 0);
        end
        @(negedge clk);
        idle_inputs();
        mem_ack = 1'b1;
        #1;
        chk("done_req", mem_req, 0);
        chk("done_wb_valid", wb_valid, 1);
        chk("done_wb_rw", wb_reg_write, acked && is_load && rw);
        chk("done_exc_to", exc_timeout, !acked);
        chk("done_stall", stall, 0);
        if (acked) chk("done_wb_rd", wb_rd, rd);
        if (acked && is_load) chk("done_wb_data", wb_data, rdata);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("stray_ack_wb", wb_valid, 0);
        chk("stray_ack_req", mem_req, 0);
        chk("stray_ack_to", exc_timeout, 0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        ex_valid = 1'b1;
        ex_mem_read = 1'b1;
        ex_alu_out = 32'h100;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rw", wb_reg_write, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_exc_mis", exc_misalign, 0);
        chk("rst_exc_to", exc_timeout, 0);
        idle_inputs();
        reset = 1'b0;

        run_alu(5'd5, 32'h1234, 1'b1);
        run_mem(1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1, 3, 32'hDEADBEEF);
        run_mem(1'b0, 1'b1, 32'h104, 32'hA5A5A5A5, 5'd3, 1'b1, 2, 32'h0);
        run_mem(1'b1, 1'b0, 32'h102, 32'h0, 5'd9, 1'b1, 1, 32'h0);
        run_mem(1'b1, 1'b0, 32'h200, 32'h0, 5'd4, 1'b1, 0, 32'h0);
        run_mem(1'b1, 1'b0, 32'h204, 32'h0, 5'd4, 1'b1, TO, 32'h13579BDF);
        run_mem(1'b1, 1'b1, 32'h208, 32'h55AA55AA, 5'd6, 1'b1, 1, 32'hFFFF0000);

        // Reset on the 2nd ACCESS cycle, then a late ack.
        @(negedge clk);
        ex_valid = 1'b1;
        ex_mem_read = 1'b1;
        ex_reg_write = 1'b1;
        ex_rd = 5'd2;
        ex_alu_out = 32'h300;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rstacc_req1", mem_req, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstacc_req2", mem_req, 1);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        chk("rstacc_req", mem_req, 0);
        chk("rstacc_addr", mem_addr, 0);
        chk("rstacc_wb", wb_valid, 0);
        chk("rstacc_stall", stall, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("late_ack_wb", wb_valid, 0);
        chk("late_ack_rw", wb_reg_write, 0);
        chk("late_ack_data", wb_data, 0);
        chk("late_ack_req", mem_req, 0);

        for (int i = 0; i < 40; i++) begin
            int kind;
            int ack;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            a = {20'h0, 10'($urandom), 2'b00};
            ack = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            if ($urandom_range(0, 9) == 0) ack = TO;
            case (kind)
                0: run_alu(5'($urandom), $urandom, 1'($urandom));
                1: run_mem(1'b1, 1'b0, a, $urandom, 5'($urandom),
                           1'($urandom), ack, $urandom);
                2: run_mem(1'b0, 1'b1, a, $urandom, 5'($urandom),
                           1'($urandom), ack, $urandom);
                3: run_mem(1'b1, 1'b1, a, $urandom, 5'($urandom),
                           1'($urandom), ack, $urandom);
                default: run_mem(1'b1, 1'($urandom),
                                 a | 32'($urandom_range(1, 3)), $urandom,
                                 5'($urandom), 1'b1, ack, $urandom);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
